tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: WIDTH, default 8, bits per channel word; legal range 2..16.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  serial bit-interleaved two-channel stream.
REQ-005 Port: din_valid  input  1  din carries a bit this cycle; cycles with din_valid=0 are ignored.
REQ-006 Port: sync  input  1  frame marker; qualified by din_valid; marks ch0 MSB.
REQ-007 Port: ready  input  1  consumer accepts output word pair this cycle.
REQ-008 Port: err_clr  input  1  clears sticky error flags.
REQ-009 Port: ch0_data  output  WIDTH  deserialized channel-0 word.
REQ-010 Port: ch1_data  output  WIDTH  deserialized channel-1 word.
REQ-011 Port: out_valid  output  1  ch0_data/ch1_data hold an unaccepted word pair.
REQ-012 Port: sel  output  1  channel owning the next valid bit (0=ch0, 1=ch1).
REQ-013 Port: overrun  output  1  sticky: completed frame dropped, output register full.
REQ-014 Port: sync_err  output  1  sticky: sync seen mid-frame.
REQ-015 Port: parity_err  output  1  sticky: parity mismatch (see Configuration).

Function
REQ-016 Frame SHALL be 2*WIDTH valid bits, interleaved: even slots to ch0, odd slots to ch1, each channel MSB first.
REQ-017 FSM SHALL have states HUNT and RECV; HUNT->RECV on din_valid&sync, that bit stored as slot 0.
REQ-018 In HUNT, valid bits without sync SHALL be discarded; sel SHALL read 0.
REQ-019 In RECV, sel SHALL toggle on every valid bit; slot counter increments per valid bit only.
REQ-020 On last slot accepted in cycle N, FSM SHALL return to HUNT at N+1.
REQ-021 If out_valid=0 or ready=1 in cycle N, ch0_data/ch1_data SHALL load and out_valid=1 at N+1 (latency 1).
REQ-022 If out_valid=1 and ready=0 in cycle N, the new frame SHALL be dropped, outputs unchanged, overrun=1 at N+1.
REQ-023 out_valid SHALL clear on ready=1 unless a new load occurs the same cycle; data SHALL hold stable while out_valid=1 and ready=0.
REQ-024 din_valid&sync in RECV at any slot other than slot 0 SHALL set sync_err, discard partial frame, restart with that bit as slot 0.
REQ-025 A sync on the bit immediately after the last slot SHALL be treated as a normal new frame start; no error.
REQ-026 err_clr=1 SHALL clear all sticky flags; an error set in the same cycle SHALL win.
REQ-027 ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 resetn=0 SHALL immediately force FSM to HUNT, slot counter 0, shift registers 0.
REQ-029 Reset values: ch0_data=0, ch1_data=0, out_valid=0, sel=0, overrun=0, sync_err=0, parity_err=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no out_valid after deassertion until a full new frame arrives.

Configuration
REQ-031 Macro TDM_DEMUX_PARITY_EN, when defined, SHALL extend the frame by one slot after the last data slot carrying even parity over all 2*WIDTH data bits.
REQ-032 With TDM_DEMUX_PARITY_EN, mismatch SHALL drop the frame and set parity_err; sel SHALL read 0 during the parity slot.
REQ-033 Without TDM_DEMUX_PARITY_EN, frame is 2*WIDTH slots and parity_err SHALL be constant 0.

Verification (WIDTH=8)
REQ-034 resetn=0 while mid-frame -> all outputs 0 immediately; no out_valid after release without a new sync frame.
REQ-035 Frame ch0=0xA5, ch1=0x3C, din_valid=1 continuous, ready=1 -> out_valid=1 one cycle after slot 15, ch0_data=0xA5, ch1_data=0x3C, out_valid=0 next cycle.
REQ-036 Same frame with din_valid=0 gaps of 3 cycles after slots 4 and 9 -> identical output values; sel unchanged across gaps.
REQ-037 ready=0, frames 0xA5/0x3C then 0x0F/0xF0 -> overrun=1, outputs still 0xA5/0x3C; err_clr=1 -> overrun=0.
REQ-038 sync reasserted at slot 5 then full frame 0x81/0x7E -> sync_err=1, outputs 0x81/0x7E, single out_valid.
REQ-039 TDM_DEMUX_PARITY_EN defined, frame 0xA5/0x3C with parity bit 1 (wrong) -> parity_err=1, out_valid stays 0; parity bit 0 -> normal load.

Source files
------------

// File: rtl/tdm_demux_if.sv
// ============================================================================
// Module   : tdm_demux_if
// Purpose  : Bundles the serial input stream, the output word pair and the
//            status flags of the two-channel TDM demultiplexer.
//            master = stream producer / word consumer, slave = demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tdm_demux_if #(
   parameter int WIDTH = 8
);
   logic             din;
   logic             din_valid;
   logic             sync;
   logic             ready;
   logic             err_clr;
   logic [WIDTH-1:0] ch0_data;
   logic [WIDTH-1:0] ch1_data;
   logic             out_valid;
   logic             sel;
   logic             overrun;
   logic             sync_err;
   logic             parity_err;

   modport master (
      output din, din_valid, sync, ready, err_clr,
      input  ch0_data, ch1_data, out_valid, sel, overrun, sync_err, parity_err
   );

   modport slave (
      input  din, din_valid, sync, ready, err_clr,
      output ch0_data, ch1_data, out_valid, sel, overrun, sync_err, parity_err
   );
endinterface

`default_nettype wire

// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Purpose  : Splits a bit-interleaved two-channel serial stream into a pair of
//            WIDTH-bit words (even slots -> ch0, odd slots -> ch1, MSB first).
//            A frame starts on a valid bit flagged by sync. Sticky flags report
//            dropped frames (overrun), misplaced sync (sync_err) and, when the
//            optional trailing parity slot is built in, parity mismatches.
// Options  : `define TDM_DEMUX_PARITY_EN adds one even-parity slot per frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
   parameter int WIDTH = 8
) (
   input  logic       clock,
   input  logic       resetn,
   tdm_demux_if.slave bus
);

   localparam int FRAME_BITS = 2 * WIDTH;
   localparam int SLOT_W     = $clog2(FRAME_BITS + 1);
   localparam logic [SLOT_W-1:0] LAST_DATA = SLOT_W'(FRAME_BITS - 1);

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t            state;
   logic [SLOT_W-1:0] slot;
   logic [WIDTH-1:0]  sr0;
   logic [WIDTH-1:0]  sr1;
   logic [WIDTH-1:0]  ch0_q;
   logic [WIDTH-1:0]  ch1_q;
   logic              out_valid_q;
   logic              sel_q;
   logic              overrun_q;
   logic              sync_err_q;

   logic              start;
   logic              data_bit;
   logic              frame_done;
   logic              load;
   logic              drop;
   logic [WIDTH-1:0]  sr0_nxt;
   logic [WIDTH-1:0]  sr1_nxt;

`ifdef TDM_DEMUX_PARITY_EN
   localparam logic [SLOT_W-1:0] PAR_SLOT = SLOT_W'(FRAME_BITS);
   logic par_acc;
   logic parity_err_q;
   logic par_bit;
   logic par_fail;
`endif

   // Decode what the current valid bit means and where a finished frame goes
   always_comb begin
      start    = bus.din_valid & bus.sync;
      data_bit = bus.din_valid & ~bus.sync & (state == RECV) & (slot <= LAST_DATA);
      sr0_nxt  = (data_bit & ~slot[0]) ? {sr0[WIDTH-2:0], bus.din} : sr0;
      sr1_nxt  = (data_bit &  slot[0]) ? {sr1[WIDTH-2:0], bus.din} : sr1;
`ifdef TDM_DEMUX_PARITY_EN
      par_bit    = bus.din_valid & ~bus.sync & (state == RECV) & (slot == PAR_SLOT);
      frame_done = par_bit & (par_acc == bus.din);
      par_fail   = par_bit & (par_acc != bus.din);
`else
      frame_done = data_bit & (slot == LAST_DATA);
`endif
      // A busy output register with no acceptance this cycle cannot take the frame
      load = frame_done & (~out_valid_q | bus.ready);
      drop = frame_done & out_valid_q & ~bus.ready;
   end

   // Frame FSM, shift registers, output word pair and sticky flags
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= HUNT;
         slot        <= '0;
         sr0         <= '0;
         sr1         <= '0;
         ch0_q       <= '0;
         ch1_q       <= '0;
         out_valid_q <= 1'b0;
         sel_q       <= 1'b0;
         overrun_q   <= 1'b0;
         sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_acc      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         if (start) begin
            // Sync bit is always slot 0; any partial frame is thrown away
            state <= RECV;
            slot  <= SLOT_W'(1);
            sr0   <= {{(WIDTH-1){1'b0}}, bus.din};
            sr1   <= '0;
            sel_q <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            par_acc <= bus.din;
`endif
         end else if (data_bit) begin
            sr0 <= sr0_nxt;
            sr1 <= sr1_nxt;
`ifdef TDM_DEMUX_PARITY_EN
            par_acc <= par_acc ^ bus.din;
            slot    <= slot + SLOT_W'(1);
            // Last data slot is odd, so sel falls to 0 for the parity slot
            sel_q   <= ~sel_q;
`else
            if (slot == LAST_DATA) begin
               state <= HUNT;
               slot  <= '0;
               sel_q <= 1'b0;
            end else begin
               slot  <= slot + SLOT_W'(1);
               sel_q <= ~sel_q;
            end
`endif
         end
`ifdef TDM_DEMUX_PARITY_EN
         else if (par_bit) begin
            state <= HUNT;
            slot  <= '0;
            sel_q <= 1'b0;
         end
         parity_err_q <= par_fail | (parity_err_q & ~bus.err_clr);
`endif

         // A sync while already receiving is necessarily off slot 0
         sync_err_q <= (start & (state == RECV)) | (sync_err_q & ~bus.err_clr);
         overrun_q  <= drop | (overrun_q & ~bus.err_clr);

         if (load) begin
            ch0_q       <= sr0_nxt;
            ch1_q       <= sr1_nxt;
            out_valid_q <= 1'b1;
         end else if (bus.ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.ch0_data  = ch0_q;
   assign bus.ch1_data  = ch1_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sel       = sel_q;
   assign bus.overrun   = overrun_q;
   assign bus.sync_err  = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : Self-checking bench for tdm_demux (WIDTH=8). Expected word pairs
//            are queued when a frame is sent and compared when the DUT hands
//            a pair over (out_valid & ready). Honours TDM_DEMUX_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

   localparam int W = 8;

   logic clk;
   logic resetn;

   int n_vec;
   int n_err;

   logic [2*W-1:0] exp_q[$];

   tdm_demux_if #(.WIDTH(W)) bus ();

   tdm_demux #(.WIDTH(W)) dut (
      .clock  (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: a pair is consumed at the next rising edge when valid & ready
   always @(negedge clk) begin
      if (resetn && bus.out_valid && bus.ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: unexpected pair ch0=%h ch1=%h, none expected",
                     bus.ch0_data, bus.ch1_data);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if ({bus.ch0_data, bus.ch1_data} !== e) begin
               n_err++;
               $display("FAIL scoreboard: got ch0=%h ch1=%h, expected ch0=%h ch1=%h",
                        bus.ch0_data, bus.ch1_data, e[2*W-1:W], e[W-1:0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic frame_bit(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                      input int k);
      if (k % 2 == 0) return c0[W-1-k/2];
      else            return c1[W-1-k/2];
   endfunction

   // Present one valid bit; returns 1ns after the edge that accepted it
   task automatic drive_bit(input logic b, input logic s);
      bus.din       = b;
      bus.sync      = s;
      bus.din_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
      bus.din       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full frame; optional idle gaps after two slots with sel checked in each gap
   task automatic send_frame(input logic [W-1:0] c0, input logic [W-1:0] c1,
                             input int gap_a, input int gap_b, input int gap_len,
                             input logic bad_par);
      for (int k = 0; k < 2*W; k++) begin
         drive_bit(frame_bit(c0, c1, k), k == 0);
         if (k == gap_a || k == gap_b) begin
            for (int g = 0; g < gap_len; g++) begin
               logic es;
               es = ((k + 1) % 2) == 1;
               idle(1);
               n_vec++;
               if (bus.sel !== es) begin
                  n_err++;
                  $display("FAIL gap_sel: slot %0d gap %0d sel=%b expected %b", k, g, bus.sel, es);
               end
            end
         end
      end
`ifdef TDM_DEMUX_PARITY_EN
      n_vec++;
      if (bus.sel !== 1'b0) begin
         n_err++;
         $display("FAIL parity_slot_sel: sel=%b expected 0", bus.sel);
      end
      drive_bit((^{c0, c1}) ^ bad_par, 1'b0);
`else
      if (bad_par) $display("note: parity slot not built, bad_par ignored");
`endif
   endtask

   task automatic reset_dut();
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
      bus.ready     = 1'b0;
      bus.err_clr   = 1'b0;
      resetn        = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      reset_dut();
      n_vec++;
      if ({bus.ch0_data, bus.ch1_data} !== '0) begin
         n_err++;
         $display("FAIL reset_data: ch0=%h ch1=%h expected 00 00", bus.ch0_data, bus.ch1_data);
      end
      n_vec++;
      if ({bus.out_valid, bus.sel, bus.overrun, bus.sync_err, bus.parity_err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: valid/sel/ovr/serr/perr=%b expected 00000",
                  {bus.out_valid, bus.sel, bus.overrun, bus.sync_err, bus.parity_err});
      end
   endtask

   task automatic test_basic();
      bus.ready = 1'b1;
      exp_q.push_back({8'hA5, 8'h3C});
      send_frame(8'hA5, 8'h3C, -1, -1, 0, 1'b0);
      n_vec++;
      if (bus.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL basic_latency: out_valid=%b expected 1", bus.out_valid);
      end
      n_vec++;
      if ({bus.ch0_data, bus.ch1_data} !== 16'hA53C) begin
         n_err++;
         $display("FAIL basic_data: got %h expected a53c", {bus.ch0_data, bus.ch1_data});
      end
      n_vec++;
      if (bus.sel !== 1'b0) begin
         n_err++;
         $display("FAIL basic_sel_hunt: sel=%b expected 0", bus.sel);
      end
      idle(1);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_clear: out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_gaps();
      exp_q.push_back({8'hA5, 8'h3C});
      send_frame(8'hA5, 8'h3C, 4, 9, 3, 1'b0);
      n_vec++;
      if (bus.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL gaps_valid: out_valid=%b expected 1", bus.out_valid);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      exp_q.push_back({8'h12, 8'h34});
      exp_q.push_back({8'hFE, 8'h01});
      send_frame(8'h12, 8'h34, -1, -1, 0, 1'b0);
      send_frame(8'hFE, 8'h01, -1, -1, 0, 1'b0);
      idle(2);
      n_vec++;
      if (bus.sync_err !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_sync_err: sync_err=%b expected 0", bus.sync_err);
      end
   endtask

   task automatic test_overrun();
      bus.ready = 1'b0;
      exp_q.push_back({8'hA5, 8'h3C});
      send_frame(8'hA5, 8'h3C, -1, -1, 0, 1'b0);
      send_frame(8'h0F, 8'hF0, -1, -1, 0, 1'b0);
      n_vec++;
      if (bus.overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_set: overrun=%b expected 1", bus.overrun);
      end
      n_vec++;
      if ({bus.out_valid, bus.ch0_data, bus.ch1_data} !== {1'b1, 16'hA53C}) begin
         n_err++;
         $display("FAIL overrun_hold: valid=%b data=%h expected 1 a53c",
                  bus.out_valid, {bus.ch0_data, bus.ch1_data});
      end
      bus.err_clr = 1'b1;
      idle(1);
      bus.err_clr = 1'b0;
      n_vec++;
      if ({bus.overrun, bus.out_valid} !== 2'b01) begin
         n_err++;
         $display("FAIL overrun_clr: overrun/valid=%b expected 01", {bus.overrun, bus.out_valid});
      end
      bus.ready = 1'b1;
      idle(1);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_drain: out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_sync_err();
      for (int k = 0; k < 5; k++) drive_bit(frame_bit(8'h12, 8'h34, k), k == 0);
      exp_q.push_back({8'h81, 8'h7E});
      send_frame(8'h81, 8'h7E, -1, -1, 0, 1'b0);
      n_vec++;
      if (bus.sync_err !== 1'b1) begin
         n_err++;
         $display("FAIL sync_err_set: sync_err=%b expected 1", bus.sync_err);
      end
      n_vec++;
      if ({bus.out_valid, bus.ch0_data, bus.ch1_data} !== {1'b1, 16'h817E}) begin
         n_err++;
         $display("FAIL sync_err_data: valid=%b data=%h expected 1 817e",
                  bus.out_valid, {bus.ch0_data, bus.ch1_data});
      end
      idle(4);
      bus.err_clr = 1'b1;
      idle(1);
      bus.err_clr = 1'b0;
      n_vec++;
      if (bus.sync_err !== 1'b0) begin
         n_err++;
         $display("FAIL sync_err_clr: sync_err=%b expected 0", bus.sync_err);
      end
   endtask

   task automatic test_parity();
`ifdef TDM_DEMUX_PARITY_EN
      send_frame(8'hA5, 8'h3C, -1, -1, 0, 1'b1);
      n_vec++;
      if ({bus.parity_err, bus.out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL parity_bad: perr/valid=%b expected 10", {bus.parity_err, bus.out_valid});
      end
      bus.err_clr = 1'b1;
      idle(1);
      bus.err_clr = 1'b0;
      exp_q.push_back({8'hA5, 8'h3C});
      send_frame(8'hA5, 8'h3C, -1, -1, 0, 1'b0);
      n_vec++;
      if ({bus.parity_err, bus.out_valid} !== 2'b01) begin
         n_err++;
         $display("FAIL parity_good: perr/valid=%b expected 01", {bus.parity_err, bus.out_valid});
      end
      idle(2);
`else
      exp_q.push_back({8'hC3, 8'h5A});
      send_frame(8'hC3, 8'h5A, -1, -1, 0, 1'b0);
      n_vec++;
      if (bus.parity_err !== 1'b0) begin
         n_err++;
         $display("FAIL parity_off: parity_err=%b expected 0", bus.parity_err);
      end
      idle(2);
`endif
   endtask

   task automatic test_reset_midframe();
      bus.ready = 1'b0;
      send_frame(8'h55, 8'hAA, -1, -1, 0, 1'b0);
      n_vec++;
      if ({bus.out_valid, bus.ch0_data, bus.ch1_data} !== {1'b1, 16'h55AA}) begin
         n_err++;
         $display("FAIL pre_reset_load: valid=%b data=%h expected 1 55aa",
                  bus.out_valid, {bus.ch0_data, bus.ch1_data});
      end
      for (int k = 0; k < 6; k++) drive_bit(frame_bit(8'hF0, 8'h0F, k), k == 0);
      #2;
      resetn = 1'b0;
      #1;
      n_vec++;
      if ({bus.out_valid, bus.sel, bus.overrun, bus.sync_err, bus.parity_err,
           bus.ch0_data, bus.ch1_data} !== '0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b sel=%b data=%h expected all zero",
                  bus.out_valid, bus.sel, {bus.ch0_data, bus.ch1_data});
      end
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      bus.ready = 1'b1;
      // Remaining bits of the interrupted frame, no sync: must be ignored
      for (int k = 6; k < 2*W + 4; k++) begin
         drive_bit(frame_bit(8'hF0, 8'h0F, k % (2*W)), 1'b0);
         n_vec++;
         if ({bus.out_valid, bus.sel} !== 2'b00) begin
            n_err++;
            $display("FAIL hunt_ignore: bit %0d valid/sel=%b expected 00", k,
                     {bus.out_valid, bus.sel});
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_overrun();
      test_sync_err();
      test_parity();
      test_reset_midframe();
      idle(2);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d pairs still expected, 0 required", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
